// File: rtl/rpu_wb_bridge.sv
// Bridge from the RPU native memory interface to one or two Wishbone-classic master ports.
// Registered request FSM with byte-lane steering, address routing, misalignment and timeout errors.
module rpu_wb_bridge #(
  parameter int unsigned             ADDR_WIDTH     = 32,
  parameter int unsigned             DATA_WIDTH     = 32,
  parameter bit                      DUAL_PORT      = 1'b0,
  parameter logic [ADDR_WIDTH-1:0]   DATA_BASE      = ADDR_WIDTH'(32'h0010_0000),
  parameter int unsigned             TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_cmd_i,
  input  logic                  mem_we_i,
  input  logic [1:0]            mem_size_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic                  mem_ready_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  mem_data_ready_o,
  output logic                  mem_err_o,
  output logic                  core_cyc_o,
  output logic                  core_stb_o,
  output logic                  core_we_o,
  output logic [3:0]            core_wstrb_o,
  output logic [ADDR_WIDTH-1:0] core_addr_o,
  output logic [DATA_WIDTH-1:0] core_data_o,
  input  logic [DATA_WIDTH-1:0] core_data_i,
  input  logic                  core_ack_i,
  output logic                  data_mem_cyc_o,
  output logic                  data_mem_stb_o,
  output logic                  data_mem_we_o,
  output logic [3:0]            data_mem_wstrb_o,
  output logic [ADDR_WIDTH-1:0] data_mem_addr_o,
  output logic [DATA_WIDTH-1:0] data_mem_data_o,
  input  logic [DATA_WIDTH-1:0] data_mem_data_i,
  input  logic                  data_mem_ack_i
);

  localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 32'd0) ? $clog2(TIMEOUT_CYCLES + 32'd1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);
  localparam bit               TO_EN    = (TIMEOUT_CYCLES != 32'd0);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, DONE = 2'd2} state_t;

  function automatic logic [3:0] lane_strobe(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] s;
    case (size)
      2'd0:    s = 4'b0001 << lane;
      2'd1:    s = 4'b0011 << {lane[1], 1'b0};
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      2'd0:    w = {4{d[7:0]}};
      2'd1:    w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] lane_rdata(input logic [1:0] size, input logic [1:0] lane,
                                             input logic [31:0] d);
    logic [31:0] sh;
    logic [31:0] r;
    sh = d >> {lane, 3'b000};
    case (size)
      2'd0:    r = {24'd0, sh[7:0]};
      2'd1:    r = lane[1] ? {16'd0, d[31:16]} : {16'd0, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  state_t                  state_r, state_s;
  logic                    sel_r, sel_s;
  logic [1:0]              size_r, size_s;
  logic [1:0]              lane_r, lane_s;
  logic [CNT_W-1:0]        cnt_r, cnt_s;
  logic                    ready_r, ready_s;
  logic                    drdy_r, drdy_s;
  logic                    err_r, err_s;
  logic [31:0]             rdata_r, rdata_s;
  logic                    c_cyc_r, c_cyc_s, c_we_r, c_we_s;
  logic [3:0]              c_strb_r, c_strb_s;
  logic [ADDR_WIDTH-1:0]   c_addr_r, c_addr_s;
  logic [31:0]             c_data_r, c_data_s;
  logic                    d_cyc_r, d_cyc_s, d_we_r, d_we_s;
  logic [3:0]              d_strb_r, d_strb_s;
  logic [ADDR_WIDTH-1:0]   d_addr_r, d_addr_s;
  logic [31:0]             d_data_r, d_data_s;
  logic                    route_s;
  logic                    bad_s;
  logic                    ack_s;
  logic [31:0]             bus_rdata_s;

  // Request decode and the ack/read-data source of the port currently in use.
  always_comb begin
    route_s     = DUAL_PORT && (mem_addr_i >= DATA_BASE);
    bad_s       = (mem_size_i == 2'd3) ||
                  ((mem_size_i == 2'd1) && mem_addr_i[0]) ||
                  ((mem_size_i == 2'd2) && (mem_addr_i[1:0] != 2'b00));
    ack_s       = sel_r ? data_mem_ack_i : core_ack_i;
    bus_rdata_s = sel_r ? data_mem_data_i : core_data_i;
  end

  // Next-state and next-output logic; every output is taken from a register.
  always_comb begin
    state_s  = state_r;
    sel_s    = sel_r;
    size_s   = size_r;
    lane_s   = lane_r;
    cnt_s    = cnt_r;
    ready_s  = ready_r;
    drdy_s   = 1'b0;
    err_s    = err_r;
    rdata_s  = rdata_r;
    c_cyc_s  = c_cyc_r;
    c_we_s   = c_we_r;
    c_strb_s = c_strb_r;
    c_addr_s = c_addr_r;
    c_data_s = c_data_r;
    d_cyc_s  = d_cyc_r;
    d_we_s   = d_we_r;
    d_strb_s = d_strb_r;
    d_addr_s = d_addr_r;
    d_data_s = d_data_r;
    case (state_r)
      IDLE: begin
        if (mem_cmd_i) begin
          ready_s = 1'b0;
          sel_s   = route_s;
          size_s  = mem_size_i;
          lane_s  = mem_addr_i[1:0];
          cnt_s   = '0;
          if (bad_s) begin
            state_s = DONE;
            drdy_s  = 1'b1;
            err_s   = 1'b1;
            rdata_s = 32'd0;
          end else if (route_s) begin
            state_s  = BUS;
            d_cyc_s  = 1'b1;
            d_we_s   = mem_we_i;
            d_strb_s = lane_strobe(mem_size_i, mem_addr_i[1:0]);
            d_addr_s = {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
            d_data_s = lane_wdata(mem_size_i, mem_data_i);
          end else begin
            state_s  = BUS;
            c_cyc_s  = 1'b1;
            c_we_s   = mem_we_i;
            c_strb_s = lane_strobe(mem_size_i, mem_addr_i[1:0]);
            c_addr_s = {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
            c_data_s = lane_wdata(mem_size_i, mem_data_i);
          end
        end else begin
          ready_s = 1'b1;
        end
      end
      BUS: begin
        // An ack on the last allowed cycle wins over the timeout.
        if (ack_s) begin
          state_s = DONE;
          drdy_s  = 1'b1;
          err_s   = 1'b0;
          rdata_s = lane_rdata(size_r, lane_r, bus_rdata_s);
          c_cyc_s = 1'b0;
          d_cyc_s = 1'b0;
        end else if (TO_EN && (cnt_r == CNT_LAST)) begin
          state_s = DONE;
          drdy_s  = 1'b1;
          err_s   = 1'b1;
          rdata_s = 32'd0;
          c_cyc_s = 1'b0;
          d_cyc_s = 1'b0;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      DONE: begin
        state_s = IDLE;
        ready_s = 1'b1;
      end
      default: begin
        state_s = IDLE;
        ready_s = 1'b1;
        c_cyc_s = 1'b0;
        d_cyc_s = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      sel_r    <= 1'b0;
      size_r   <= 2'd0;
      lane_r   <= 2'd0;
      cnt_r    <= '0;
      ready_r  <= 1'b1;
      drdy_r   <= 1'b0;
      err_r    <= 1'b0;
      rdata_r  <= 32'd0;
      c_cyc_r  <= 1'b0;
      c_we_r   <= 1'b0;
      c_strb_r <= 4'd0;
      c_addr_r <= '0;
      c_data_r <= 32'd0;
      d_cyc_r  <= 1'b0;
      d_we_r   <= 1'b0;
      d_strb_r <= 4'd0;
      d_addr_r <= '0;
      d_data_r <= 32'd0;
    end else begin
      state_r  <= state_s;
      sel_r    <= sel_s;
      size_r   <= size_s;
      lane_r   <= lane_s;
      cnt_r    <= cnt_s;
      ready_r  <= ready_s;
      drdy_r   <= drdy_s;
      err_r    <= err_s;
      rdata_r  <= rdata_s;
      c_cyc_r  <= c_cyc_s;
      c_we_r   <= c_we_s;
      c_strb_r <= c_strb_s;
      c_addr_r <= c_addr_s;
      c_data_r <= c_data_s;
      d_cyc_r  <= d_cyc_s;
      d_we_r   <= d_we_s;
      d_strb_r <= d_strb_s;
      d_addr_r <= d_addr_s;
      d_data_r <= d_data_s;
    end
  end

  assign mem_ready_o      = ready_r;
  assign mem_data_o       = rdata_r;
  assign mem_data_ready_o = drdy_r;
  assign mem_err_o        = err_r;
  assign core_cyc_o       = c_cyc_r;
  assign core_stb_o       = c_cyc_r;
  assign core_we_o        = c_we_r;
  assign core_wstrb_o     = c_strb_r;
  assign core_addr_o      = c_addr_r;
  assign core_data_o      = c_data_r;
  assign data_mem_cyc_o   = d_cyc_r;
  assign data_mem_stb_o   = d_cyc_r;
  assign data_mem_we_o    = d_we_r;
  assign data_mem_wstrb_o = d_strb_r;
  assign data_mem_addr_o  = d_addr_r;
  assign data_mem_data_o  = d_data_r;

endmodule

// File: tb/tb_rpu_wb_bridge.sv
// Directed bench for rpu_wb_bridge: a dual-port instance with a short timeout plus a
// single-port instance whose ack is tied high, both fed from the same request lines.
module tb_rpu_wb_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_cmd = 1'b0, mem_we = 1'b0;
  logic [1:0]  mem_size = 2'd0;
  logic [31:0] mem_addr = 32'd0, mem_wdata = 32'd0;
  logic        mem_ready, mem_drdy, mem_err;
  logic [31:0] mem_rdata;
  logic        core_cyc, core_stb, core_we, core_ack = 1'b0;
  logic [3:0]  core_wstrb;
  logic [31:0] core_addr, core_wdata, core_rdata = 32'd0;
  logic        dm_cyc, dm_stb, dm_we, dm_ack = 1'b0;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_addr, dm_wdata, dm_rdata = 32'd0;
  logic        sp_ready, sp_drdy, sp_err, sp_ack = 1'b1, sp_dm_ack = 1'b0;
  logic [31:0] sp_rdata;
  logic        sp_cyc, sp_stb, sp_we, sp_dm_cyc, sp_dm_stb, sp_dm_we;
  logic [3:0]  sp_wstrb, sp_dm_wstrb;
  logic [31:0] sp_addr, sp_wdata, sp_dm_addr, sp_dm_wdata;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rpu_wb_bridge #(.DUAL_PORT(1'b1), .DATA_BASE(32'h0010_0000), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem_cmd_i(mem_cmd), .mem_we_i(mem_we), .mem_size_i(mem_size),
    .mem_addr_i(mem_addr), .mem_data_i(mem_wdata), .mem_ready_o(mem_ready), .mem_data_o(mem_rdata),
    .mem_data_ready_o(mem_drdy), .mem_err_o(mem_err),
    .core_cyc_o(core_cyc), .core_stb_o(core_stb), .core_we_o(core_we), .core_wstrb_o(core_wstrb),
    .core_addr_o(core_addr), .core_data_o(core_wdata), .core_data_i(core_rdata), .core_ack_i(core_ack),
    .data_mem_cyc_o(dm_cyc), .data_mem_stb_o(dm_stb), .data_mem_we_o(dm_we),
    .data_mem_wstrb_o(dm_wstrb), .data_mem_addr_o(dm_addr), .data_mem_data_o(dm_wdata),
    .data_mem_data_i(dm_rdata), .data_mem_ack_i(dm_ack));

  rpu_wb_bridge #(.DUAL_PORT(1'b0)) u_sp (
    .clk(clk), .rst_n(rst_n), .mem_cmd_i(mem_cmd), .mem_we_i(mem_we), .mem_size_i(mem_size),
    .mem_addr_i(mem_addr), .mem_data_i(mem_wdata), .mem_ready_o(sp_ready), .mem_data_o(sp_rdata),
    .mem_data_ready_o(sp_drdy), .mem_err_o(sp_err),
    .core_cyc_o(sp_cyc), .core_stb_o(sp_stb), .core_we_o(sp_we), .core_wstrb_o(sp_wstrb),
    .core_addr_o(sp_addr), .core_data_o(sp_wdata), .core_data_i(core_rdata), .core_ack_i(sp_ack),
    .data_mem_cyc_o(sp_dm_cyc), .data_mem_stb_o(sp_dm_stb), .data_mem_we_o(sp_dm_we),
    .data_mem_wstrb_o(sp_dm_wstrb), .data_mem_addr_o(sp_dm_addr), .data_mem_data_o(sp_dm_wdata),
    .data_mem_data_i(dm_rdata), .data_mem_ack_i(sp_dm_ack));

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;   // bus cycles without ack before the ack cycle
    logic        stray;   // pulse the other port's ack in the first bus cycle
    logic        port;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_access(input int idx, input vec_t v);
    string t;
    t = $sformatf("v%0d", idx);
    chk({t, ".ready_idle"}, {31'd0, mem_ready}, 32'd1);
    mem_cmd = 1'b1; mem_we = v.we; mem_size = v.size; mem_addr = v.addr; mem_wdata = v.wdata;
    core_rdata = v.rdata; dm_rdata = v.rdata;
    tick();
    mem_cmd = 1'b0;
    chk({t, ".ready_busy"}, {31'd0, mem_ready}, 32'd0);
    if (v.e_err) begin
      chk({t, ".err_drdy"}, {31'd0, mem_drdy}, 32'd1);
      chk({t, ".err_flag"}, {31'd0, mem_err}, 32'd1);
      chk({t, ".err_data"}, mem_rdata, 32'd0);
      chk({t, ".err_nocyc"}, {30'd0, core_cyc, dm_cyc}, 32'd0);
      chk({t, ".sp_err"}, {30'd0, sp_drdy, sp_err}, 32'd3);
      tick();
      chk({t, ".err_drdy_end"}, {31'd0, mem_drdy}, 32'd0);
      chk({t, ".err_ready"}, {31'd0, mem_ready}, 32'd1);
      chk({t, ".err_nocyc2"}, {30'd0, core_cyc, dm_cyc}, 32'd0);
    end else begin
      chk({t, ".cyc_stb"}, v.port ? {30'd0, dm_cyc, dm_stb} : {30'd0, core_cyc, core_stb}, 32'd3);
      chk({t, ".other_cyc"}, v.port ? {30'd0, core_cyc, core_stb} : {30'd0, dm_cyc, dm_stb}, 32'd0);
      chk({t, ".addr"}, v.port ? dm_addr : core_addr, v.e_addr);
      chk({t, ".wstrb"}, {28'd0, v.port ? dm_wstrb : core_wstrb}, {28'd0, v.e_strb});
      chk({t, ".we"}, {31'd0, v.port ? dm_we : core_we}, {31'd0, v.we});
      if (v.we) chk({t, ".wdata"}, v.port ? dm_wdata : core_wdata, v.e_wdata);
      chk({t, ".sp_route"}, {30'd0, sp_cyc, sp_dm_cyc}, 32'd2);
      chk({t, ".sp_addr"}, sp_addr, v.e_addr);
      if (v.stray) begin
        if (v.port) core_ack = 1'b1;
        else dm_ack = 1'b1;
      end
      for (int c = 0; c < v.delay; c++) begin
        tick();
        core_ack = 1'b0; dm_ack = 1'b0;
        chk($sformatf("%s.wait%0d_drdy", t, c), {31'd0, mem_drdy}, 32'd0);
        chk($sformatf("%s.wait%0d_cyc", t, c), {31'd0, v.port ? dm_cyc : core_cyc}, 32'd1);
      end
      if (v.port) dm_ack = 1'b1;
      else core_ack = 1'b1;
      tick();
      core_ack = 1'b0; dm_ack = 1'b0;
      chk({t, ".cyc_drop"}, {30'd0, core_cyc, dm_cyc}, 32'd0);
      chk({t, ".drdy"}, {31'd0, mem_drdy}, 32'd1);
      chk({t, ".err"}, {31'd0, mem_err}, 32'd0);
      if (!v.we) begin
        chk({t, ".rdata"}, mem_rdata, v.e_rdata);
        chk({t, ".sp_rdata"}, sp_rdata, v.e_rdata);
      end
      tick();
      chk({t, ".drdy_end"}, {31'd0, mem_drdy}, 32'd0);
      chk({t, ".ready_again"}, {31'd0, mem_ready}, 32'd1);
      if (!v.we) chk({t, ".rdata_hold"}, mem_rdata, v.e_rdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          we    size  addr           wdata          rdata          dly st   port  e_addr         strb     e_wdata        e_rdata        err
    vt[0]  = '{1'b0, 2'd2, 32'h0000_0100, 32'h0000_0000, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, 32'h0000_0100, 4'b1111, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vt[1]  = '{1'b1, 2'd0, 32'h0000_0203, 32'h0000_00A5, 32'h0000_0000, 0, 1'b0, 1'b0, 32'h0000_0200, 4'b1000, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0};
    vt[2]  = '{1'b0, 2'd0, 32'h0000_0202, 32'h0000_0000, 32'h1122_3344, 0, 1'b0, 1'b0, 32'h0000_0200, 4'b0100, 32'h0000_0000, 32'h0000_0022, 1'b0};
    vt[3]  = '{1'b0, 2'd1, 32'h0000_0101, 32'h0000_0000, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 32'h0000_0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vt[4]  = '{1'b0, 2'd3, 32'h0000_0100, 32'h0000_0000, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 32'h0000_0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vt[5]  = '{1'b1, 2'd2, 32'h0000_0102, 32'h1234_5678, 32'h0000_0000, 0, 1'b0, 1'b0, 32'h0000_0000, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vt[6]  = '{1'b1, 2'd1, 32'h0000_0106, 32'h1234_BEEF, 32'h0000_0000, 2, 1'b0, 1'b0, 32'h0000_0104, 4'b1100, 32'hBEEF_BEEF, 32'h0000_0000, 1'b0};
    vt[7]  = '{1'b0, 2'd1, 32'h000F_FFFE, 32'h0000_0000, 32'hCAFE_1234, 1, 1'b0, 1'b0, 32'h000F_FFFC, 4'b1100, 32'h0000_0000, 32'h0000_CAFE, 1'b0};
    vt[8]  = '{1'b1, 2'd2, 32'h0010_0004, 32'h0102_0304, 32'h0000_0000, 1, 1'b1, 1'b1, 32'h0010_0004, 4'b1111, 32'h0102_0304, 32'h0000_0000, 1'b0};
    vt[9]  = '{1'b0, 2'd0, 32'h0010_0001, 32'h0000_0000, 32'hAABB_CCDD, 3, 1'b0, 1'b1, 32'h0010_0000, 4'b0010, 32'h0000_0000, 32'h0000_00CC, 1'b0};
    vt[10] = '{1'b0, 2'd2, 32'h000F_FFFC, 32'h0000_0000, 32'h5A5A_0F0F, 0, 1'b0, 1'b0, 32'h000F_FFFC, 4'b1111, 32'h0000_0000, 32'h5A5A_0F0F, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst.ready", {31'd0, mem_ready}, 32'd1);
    chk("rst.ctrl", {26'd0, core_cyc, core_stb, core_we, dm_cyc, dm_stb, dm_we}, 32'd0);
    chk("rst.drdy_err", {30'd0, mem_drdy, mem_err}, 32'd0);
    chk("rst.rdata", mem_rdata, 32'd0);
    chk("rst.addr", core_addr | dm_addr, 32'd0);
    chk("rst.wstrb_data", {24'd0, core_wstrb, dm_wstrb} | core_wdata | dm_wdata, 32'd0);
    rst_n = 1'b1;
    tick();

    // An ack while idle must not produce a completion.
    core_ack = 1'b1;
    tick();
    core_ack = 1'b0;
    chk("idle_ack.drdy", {31'd0, mem_drdy}, 32'd0);
    chk("idle_ack.ready", {31'd0, mem_ready}, 32'd1);

    for (int i = 0; i < 11; i++) run_access(i, vt[i]);

    // Timeout: no ack for four bus cycles.
    mem_cmd = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_addr = 32'h0000_0200;
    tick();
    mem_cmd = 1'b0;
    chk("to.cyc0", {31'd0, core_cyc}, 32'd1);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk($sformatf("to.cyc%0d", k), {31'd0, core_cyc}, 32'd1);
      chk($sformatf("to.drdy%0d", k), {31'd0, mem_drdy}, 32'd0);
    end
    tick();
    chk("to.cyc_drop", {30'd0, core_cyc, core_stb}, 32'd0);
    chk("to.drdy", {31'd0, mem_drdy}, 32'd1);
    chk("to.err", {31'd0, mem_err}, 32'd1);
    chk("to.rdata", mem_rdata, 32'd0);
    tick();
    chk("to.ready", {31'd0, mem_ready}, 32'd1);

    // Reset asserted while the access is on the bus.
    mem_cmd = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_addr = 32'h0000_0300;
    tick();
    mem_cmd = 1'b0;
    tick();
    chk("mid.cyc_before", {31'd0, core_cyc}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid.cyc_async", {30'd0, core_cyc, core_stb}, 32'd0);
    chk("mid.ready", {31'd0, mem_ready}, 32'd1);
    chk("mid.drdy", {31'd0, mem_drdy}, 32'd0);
    tick();
    chk("mid.drdy_hold", {31'd0, mem_drdy}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("mid.drdy_after", {31'd0, mem_drdy}, 32'd0);
    run_access(100, vt[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
